// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing the register file write port.
// Stage p0 picks one requester per cycle (combinational gnt).
// Stage p1 registers the winner's destination/data onto the rf_* outputs.
// Optional burst lock mode is built when RF_ARB_LOCK_EN is defined.
module regfile_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 3,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] waddr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               rf_wr,
  output logic [AW-1:0]      rf_seti,
  output logic [DW-1:0]      rf_input,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr_p0;
  logic [PW-1:0]     ptr_nxt;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [PW-1:0]     rr_win;
  logic              rr_any;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [AW-1:0]     addr_sel;
  logic [DW-1:0]     data_sel;

  logic              vld_p1;
  logic [AW-1:0]     addr_p1;
  logic [DW-1:0]     data_p1;

  // ---- stage p0: round-robin search starting at ptr ----
  assign req_dbl = {req, req};
  assign req_rot = NREQ'(req_dbl >> ptr_p0);

  always_comb begin
    int sum;
    rr_any = 1'b0;
    rr_win = '0;
    sum    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rr_any = 1'b1;
        sum    = int'(ptr_p0) + k;
      end
    end
    if (sum >= NREQ) sum = sum - NREQ;
    rr_win = PW'(sum);
  end

`ifdef RF_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state_p0;
  state_t        state_nxt;
  logic [PW-1:0] owner_p0;
  logic [PW-1:0] owner_nxt;
  logic [CW-1:0] cnt_p0;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state_p0;
    owner_nxt = owner_p0;
    cnt_nxt   = cnt_p0;
    gnt_any   = 1'b0;
    gnt_idx   = rr_win;
    case (state_p0)
      ARB: begin
        if (rr_any) begin
          gnt_any = 1'b1;
          if (lock[rr_win] && (MAX_BURST > 1)) begin
            state_nxt = LOCKED;
            owner_nxt = rr_win;
            cnt_nxt   = CW'(1);
          end
        end
      end
      LOCKED: begin
        gnt_idx = owner_p0;
        if (req[owner_p0]) begin
          gnt_any = 1'b1;
          if (lock[owner_p0] && (int'(cnt_p0) + 1 < MAX_BURST)) begin
            cnt_nxt = cnt_p0 + CW'(1);
          end else begin
            state_nxt = ARB;
            cnt_nxt   = '0;
          end
        end else begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= ARB;
      owner_p0 <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      owner_p0 <= owner_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign busy = (state_p0 == LOCKED);
`else
  logic unused_lock;

  assign gnt_any     = rr_any;
  assign gnt_idx     = rr_win;
  assign busy        = 1'b0;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    int nxt;
    gnt      = '0;
    addr_sel = '0;
    data_sel = '0;
    nxt      = int'(gnt_idx) + 1;
    if (nxt >= NREQ) nxt = 0;
    ptr_nxt  = gnt_any ? PW'(nxt) : ptr_p0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_any && !reset && (gnt_idx == PW'(i))) begin
        gnt[i]   = 1'b1;
        addr_sel = waddr[i*AW +: AW];
        data_sel = wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_p0 <= '0;
    end else begin
      ptr_p0 <= ptr_nxt;
    end
  end

  // ---- stage p1: registered write to the register file ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= |gnt;
      if (|gnt) begin
        addr_p1 <= addr_sel;
        data_p1 <= data_sel;
      end
    end
  end

  assign rf_wr    = vld_p1;
  assign rf_seti  = addr_p1;
  assign rf_input = data_p1;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter (NREQ=4, AW=3, DW=32, MAX_BURST=4).
// Lock-mode sequences are compiled in when RF_ARB_LOCK_EN is defined.
module tb_regfile_wr_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [11:0]  waddr;
  logic [127:0] wdata;
  logic [3:0]   gnt;
  logic         rf_wr;
  logic [2:0]   rf_seti;
  logic [31:0]  rf_input;
  logic         busy;

  regfile_wr_arbiter #(
    .NREQ(4), .AW(3), .DW(32), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .waddr(waddr), .wdata(wdata), .gnt(gnt),
    .rf_wr(rf_wr), .rf_seti(rf_seti), .rf_input(rf_input), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] eg;
    logic       eb;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [31:0] d;
  } rf_exp_t;

  vec_t        tbl [18];
  rf_exp_t     sb [$];
  logic [2:0]  addr_t [4];
  logic [31:0] data_t [4];
  logic [2:0]  m_addr;
  logic [31:0] m_data;
  int          errors;
  int          checks;
  logic        watch;
  int          bad_hits;

  always @(negedge clk) begin
    if (watch && rf_wr && (rf_input == 32'h0BADF00D)) bad_hits++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock cycle: drive, check gnt/busy mid-cycle, then check rf_* after the edge.
  task automatic cycle(input logic rs, input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] eg, input logic eb, input string tag);
    rf_exp_t e;
    int      gi;
    reset = rs;
    req   = r;
    lock  = l;
    for (int i = 0; i < 4; i++) begin
      waddr[i*3 +: 3]   = addr_t[i];
      wdata[i*32 +: 32] = data_t[i];
    end
    @(negedge clk);
    chk({tag, " gnt"}, 64'(gnt), 64'(eg));
    if (eb !== 1'bx) chk({tag, " busy"}, 64'(busy), 64'(eb));
    gi = oh_idx(eg);
    if (rs) begin
      m_addr = '0;
      m_data = '0;
      e.wr = 1'b0;
    end else if (gi >= 0) begin
      m_addr = addr_t[gi];
      m_data = data_t[gi];
      e.wr = 1'b1;
    end else begin
      e.wr = 1'b0;
    end
    e.a = m_addr;
    e.d = m_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!rs && gi >= 0) begin
      addr_t[gi] = 3'($urandom_range(0, 7));
      data_t[gi] = $urandom;
    end
    e = sb.pop_front();
    chk({tag, " rf_wr"},    64'(rf_wr),    64'(e.wr));
    chk({tag, " rf_seti"},  64'(rf_seti),  64'(e.a));
    chk({tag, " rf_input"}, 64'(rf_input), 64'(e.d));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    errors   = 0;
    checks   = 0;
    watch    = 1'b0;
    bad_hits = 0;
    reset    = 1'b1;
    req      = '0;
    lock     = '0;
    waddr    = '0;
    wdata    = '0;
    m_addr   = '0;
    m_data   = '0;
    for (int i = 0; i < 4; i++) begin
      addr_t[i] = 3'(i);
      data_t[i] = 32'h1000_0000 + i;
    end

    // rs, req, lock, expected gnt, expected busy (ptr=0 after entry 0)
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b0};
    tbl[9]  = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b0};
    tbl[10] = '{1'b0, 4'b1010, 4'b0000, 4'b1000, 1'b0};
    tbl[11] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0};
    tbl[14] = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b0};
    tbl[15] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 1'b0};
    tbl[16] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0};
    tbl[17] = '{1'b0, 4'b1110, 4'b0000, 4'b0010, 1'b0};

    repeat (2) @(posedge clk);
    #1;

    // Reset state, and gnt forced low while reset is high.
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, "rst0");
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "rst1");

    // Single write from requester 0.
    addr_t[0] = 3'd3;
    data_t[0] = 32'hDEADBEEF;
    cycle(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, "single");
    chk("single seti const", 64'(rf_seti), 64'd3);
    chk("single data const", 64'(rf_input), 64'hDEADBEEF);
    cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "hold");

    for (int v = 0; v < 18; v++) begin
      cycle(tbl[v].rs, tbl[v].req, tbl[v].lock, tbl[v].eg, tbl[v].eb,
            $sformatf("vec%0d", v));
    end

    // Reset during a would-be grant to requester 1; search restarts at 0.
    cycle(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, "pre_rst");
    cycle(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, "rst_gnt1");
    chk("rst_gnt1 seti zero", 64'(rf_seti), 64'd0);
    chk("rst_gnt1 data zero", 64'(rf_input), 64'd0);
    cycle(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, "post_rst");

    // Requester 0 withdraws while requester 3 is granted.
    cycle(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, "wd_setup");
    addr_t[0] = 3'd7;
    data_t[0] = 32'h0BADF00D;
    addr_t[3] = 3'd5;
    data_t[3] = 32'h33333333;
    watch = 1'b1;
    cycle(1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b0, "wd_g3");
    cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "wd_drop");
    cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "wd_idle");
    watch = 1'b0;
    chk("withdraw no write", 64'(bad_hits), 64'd0);

`ifdef RF_ARB_LOCK_EN
    // Burst of MAX_BURST grants to requester 0, then requester 1.
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "lk_rst");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "lk_b1");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1, "lk_b2");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1, "lk_b3");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b1, "lk_b4");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0010, 1'b0, "lk_b5");
    // Owner 2 drops req for a cycle: idle, then requester 1.
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "lk_rst2");
    cycle(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, "lk_own2");
    cycle(1'b0, 4'b0010, 4'b0100, 4'b0000, 1'b1, "lk_drop");
    cycle(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, "lk_after");
    // lock released: final beat to owner, then round robin resumes.
    cycle(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0, "lk_own3");
    cycle(1'b0, 4'b1001, 4'b0000, 4'b1000, 1'b1, "lk_final");
    cycle(1'b0, 4'b1001, 4'b0000, 4'b0001, 1'b0, "lk_next");
    // Reset in the middle of a burst.
    cycle(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0, "lk_own1");
    cycle(1'b1, 4'b0010, 4'b0010, 4'b0000, 1'bx, "lk_rstmid");
    chk("lk_rstmid busy after", 64'(busy), 64'd0);
    cycle(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, "lk_resume");
`else
    // lock input has no effect: plain rotation, busy stays low.
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "nl_rst");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "nl_g0");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0010, 1'b0, "nl_g1");
    cycle(1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0, "nl_g0b");
`endif

    cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "end_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
